mono_data_rx_merge: RTL and testbench
=====================================

Name: mono_data_rx_merge

Overview:
- Parametrised successor receiver stage that merges up to 8 decoded hit-word streams into one 32-bit output FIFO.
- Each stream comes from a per-chip or per-column receiver core.
- Arbitration is fair round-robin; each word is tagged with the identifier and its channel index.
- Full behaviour is selectable: back-pressure or drop-and-count. Channels can be enabled individually, and all inputs can be muted globally.
- Sits between the receiver cores and the readout FIFO arbiter, in the BUS_CLK domain.

Parameters:
- CHANNELS, 4, number of input streams (1..8).
- DEPTH, 16, output FIFO depth in words (power of 2, 4..1024).
- DROP_ON_FULL, 1, 1 = drop granted word when FIFO full and count it lost; 0 = stall inputs.
- IDENTYFIER, 2'b00, 2-bit tag placed in bits [31:30] of every output word.

Ports:
- BUS_CLK  input  1  single clock for the whole block.
- BUS_RST  input  1  synchronous active-high reset.
- CH_VALID  input  CHANNELS  per-channel word valid.
- CH_DATA  input  27*CHANNELS  per-channel payload; channel i occupies [27*i+26:27*i].
- CH_READY  output  CHANNELS  per-channel accept; a transfer occurs on CH_VALID[i]&CH_READY[i] at a clock edge.
- CH_ENABLE  input  CHANNELS  per-channel enable.
- MUTE  input  1  global discard of all input words.
- CLEAR_LOST  input  1  synchronous clear of LOST_CNT.
- FIFO_READ  input  1  pop request.
- FIFO_EMPTY  output  1  FIFO holds no word.
- FIFO_FULL  output  1  FIFO holds DEPTH words.
- FIFO_DATA  output  32  head word, first-word-fall-through.
- LOST_CNT  output  8  saturating count of dropped words.
- LOST_ERROR  output  1  high when LOST_CNT != 0.

Behaviour:
- Reset:
  - FIFO emptied: FIFO_EMPTY=1, FIFO_FULL=0, FIFO_DATA=0.
  - LOST_CNT=0, LOST_ERROR=0.
  - Round-robin pointer last_grant=CHANNELS-1, so channel 0 has highest priority first.
  - CH_READY follows the combinational rules below from reset values.
- Output word format: {IDENTYFIER[1:0], ch_index[2:0], payload[26:0]}.
- Disabled channel (CH_ENABLE[i]=0): CH_READY[i]=1; words are discarded, not counted, and never granted.
- MUTE=1: CH_READY=all ones for every channel; all words are discarded, not counted; the arbiter pointer is frozen.
- Arbitration, evaluated combinationally each cycle:
  - Requesters are channels with CH_VALID & CH_ENABLE while MUTE=0.
  - The grant goes to the first requester searching from last_grant+1 upward, modulo CHANNELS.
  - At most one grant per cycle.
  - On a transfer, last_grant <= granted index.
  - No requesters: pointer unchanged.
- CH_READY for enabled channels with MUTE=0:
  - Granted channel: CH_READY=1 if FIFO_FULL=0, or if DROP_ON_FULL=1.
  - All other enabled channels: CH_READY=0.
- Write:
  - A granted transfer with FIFO_FULL=0 writes the tagged word.
  - A granted transfer with FIFO_FULL=1 (DROP_ON_FULL=1 only) discards the word and increments LOST_CNT.
  - FIFO_FULL is registered from the count, so a same-cycle FIFO_READ does not unblock a write.
- Read:
  - FIFO_READ with FIFO_EMPTY=0 pops the head.
  - FIFO_READ while empty is ignored with no underflow.
  - FIFO_DATA is valid whenever FIFO_EMPTY=0.
  - Simultaneous write and read when not full and not empty: count unchanged, both take effect.
- Latency: a word accepted at edge N appears at FIFO_DATA with FIFO_EMPTY=0 after edge N (one cycle) when the FIFO was empty.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- LOST_CNT:
  - Saturates at 255.
  - CLEAR_LOST has priority over a same-cycle increment, so the result is 0.
  - LOST_ERROR is combinational from LOST_CNT.
- Reset asserted mid-transfer: the word is not written, all state returns to reset values next edge, and any stored words are lost.
- CHANNELS=1: arbiter degenerates to a pass-through; ch_index=0.

Test Plan:
- Reset, then CH_VALID[0]=1 with payload 27'h1234567 for one cycle, IDENTYFIER=2'b10 -> one cycle later FIFO_EMPTY=0, FIFO_DATA=32'h81234567.
- All 4 channels continuously valid, FIFO_READ held high -> grant order 0,1,2,3,0,...; ch_index field cycles 0..3; no channel is granted twice before the others.
- DROP_ON_FULL=1, no reads, channel 2 sends 20 words into DEPTH=16 -> FIFO_FULL=1 after 16 words, LOST_CNT=4, LOST_ERROR=1; CLEAR_LOST -> 0. Pushing 300 extra words -> LOST_CNT stays at 255.
- DROP_ON_FULL=0, FIFO full, channel 1 valid -> CH_READY[1]=0 and the word is held; one FIFO_READ -> next cycle CH_READY[1]=1, word written, LOST_CNT stays 0.
- MUTE=1 with channels valid, or CH_ENABLE[3]=0 with channel 3 valid -> CH_READY high for the affected channels, FIFO stays empty, LOST_CNT=0.
- FIFO_READ pulsed while empty, then 16 write/read pairs across the pointer wrap -> no underflow, data order preserved, FIFO_EMPTY=1 at end.

Source files
------------

// File: rtl/mono_data_rx_merge.sv
// mono_data_rx_merge
// Merges up to 8 decoded 27-bit hit-word streams into one 32-bit
// first-word-fall-through FIFO. A round-robin arbiter picks one requesting
// channel per cycle and tags its word with the block identifier and the
// channel index. When the FIFO is full the granted word is either dropped
// and counted (DROP_ON_FULL=1) or held back by deasserting CH_READY.
module mono_data_rx_merge #(
    parameter int         CHANNELS     = 4,
    parameter int         DEPTH        = 16,
    parameter int         DROP_ON_FULL = 1,
    parameter logic [1:0] IDENTYFIER   = 2'b00
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic [CHANNELS-1:0]      CH_VALID,
    input  logic [27*CHANNELS-1:0]   CH_DATA,
    output logic [CHANNELS-1:0]      CH_READY,
    input  logic [CHANNELS-1:0]      CH_ENABLE,
    input  logic                     MUTE,
    input  logic                     CLEAR_LOST,
    input  logic                     FIFO_READ,
    output logic                     FIFO_EMPTY,
    output logic                     FIFO_FULL,
    output logic [31:0]              FIFO_DATA,
    output logic [7:0]               LOST_CNT,
    output logic                     LOST_ERROR
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic       DROP     = (DROP_ON_FULL != 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]    last_grant_q, last_grant_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic [7:0]    lost_q, lost_d;
    logic [31:0]   mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] gnt_oh;
    logic                gnt_vld;
    logic [2:0]          gnt_idx;
    logic [26:0]         gnt_payload;
    logic                xfer;
    logic                wr_en;
    logic                drop_en;
    logic                rd_en;
    logic [31:0]         wr_word;

    // Only enabled, valid channels compete; MUTE removes everyone, which
    // also freezes the round-robin pointer.
    assign req = CH_VALID & CH_ENABLE & {CHANNELS{~MUTE}};

    // Round-robin search: each requester's distance from last_grant+1
    // (mod CHANNELS) is computed and the nearest one wins.
    always_comb begin
        int best;
        int d;
        best    = CHANNELS;
        d       = 0;
        gnt_vld = 1'b0;
        gnt_idx = last_grant_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (req[i]) begin
                d = i - int'(last_grant_q) - 1;
                if (d < 0) d = d + CHANNELS;
                if (d < best) begin
                    best    = d;
                    gnt_vld = 1'b1;
                    gnt_idx = 3'(i);
                end
            end
        end
    end

    // One-hot grant and payload mux for the winning channel.
    always_comb begin
        gnt_oh      = '0;
        gnt_payload = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_idx == 3'(i));
            if (gnt_oh[i]) gnt_payload = CH_DATA[27*i +: 27];
        end
    end

    // Handshake: disabled or muted channels are always drained; the granted
    // channel is accepted unless the FIFO is full and we are stalling.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            CH_READY[i] = MUTE | ~CH_ENABLE[i] | (gnt_oh[i] & (~full_q | DROP));
        end
    end

    // Write/drop/read qualification. full_q is a register, so a read in the
    // same cycle never frees room for a write.
    always_comb begin
        xfer    = gnt_vld & (~full_q | DROP);
        wr_en   = gnt_vld & ~full_q;
        drop_en = gnt_vld & full_q & DROP;
        rd_en   = FIFO_READ & (cnt_q != '0);
        wr_word = {IDENTYFIER, gnt_idx, gnt_payload};
    end

    // Next-state for pointer, FIFO bookkeeping and lost counter.
    always_comb begin
        last_grant_d = last_grant_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        lost_d       = lost_q;

        if (xfer) last_grant_d = gnt_idx;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;

        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        full_d = (cnt_d == FULL_CNT);

        // Clear wins over a same-cycle drop; the counter sticks at 255.
        if (CLEAR_LOST) lost_d = '0;
        else if (drop_en && lost_q != 8'hFF) lost_d = lost_q + 1'b1;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            last_grant_q <= 3'(CHANNELS-1);
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            lost_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            lost_q       <= lost_d;
        end
    end

    // FIFO storage; a word arriving during reset is not stored.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST && wr_en) mem_q[wptr_q] <= wr_word;
    end

    assign FIFO_EMPTY = (cnt_q == '0);
    assign FIFO_FULL  = full_q;
    assign FIFO_DATA  = FIFO_EMPTY ? 32'h0 : mem_q[rptr_q];
    assign LOST_CNT   = lost_q;
    assign LOST_ERROR = (lost_q != 8'h00);

endmodule

// File: tb/tb_mono_data_rx_merge.sv
// Testbench for mono_data_rx_merge: one drop-on-full and one stalling
// instance share all inputs; each test checks the instance it targets.
module tb_mono_data_rx_merge;

    localparam int CH = 4;

    logic            BUS_CLK = 1'b0;
    logic            BUS_RST;
    logic [CH-1:0]   CH_VALID;
    logic [27*CH-1:0] CH_DATA;
    logic [CH-1:0]   CH_ENABLE;
    logic            MUTE;
    logic            CLEAR_LOST;
    logic            FIFO_READ;

    logic [CH-1:0]   rdy_a, rdy_b;
    logic            emp_a, emp_b, ful_a, ful_b, err_a, err_b;
    logic [31:0]     dat_a, dat_b;
    logic [7:0]      lost_a, lost_b;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] sbq [$];

    always #5 BUS_CLK = ~BUS_CLK;

    mono_data_rx_merge #(.CHANNELS(CH), .DEPTH(16), .DROP_ON_FULL(1), .IDENTYFIER(2'b10)) u_drop (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .CH_VALID(CH_VALID), .CH_DATA(CH_DATA),
        .CH_READY(rdy_a), .CH_ENABLE(CH_ENABLE), .MUTE(MUTE), .CLEAR_LOST(CLEAR_LOST),
        .FIFO_READ(FIFO_READ), .FIFO_EMPTY(emp_a), .FIFO_FULL(ful_a), .FIFO_DATA(dat_a),
        .LOST_CNT(lost_a), .LOST_ERROR(err_a));

    mono_data_rx_merge #(.CHANNELS(CH), .DEPTH(16), .DROP_ON_FULL(0), .IDENTYFIER(2'b10)) u_stall (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .CH_VALID(CH_VALID), .CH_DATA(CH_DATA),
        .CH_READY(rdy_b), .CH_ENABLE(CH_ENABLE), .MUTE(MUTE), .CLEAR_LOST(CLEAR_LOST),
        .FIFO_READ(FIFO_READ), .FIFO_EMPTY(emp_b), .FIFO_FULL(ful_b), .FIFO_DATA(dat_b),
        .LOST_CNT(lost_b), .LOST_ERROR(err_b));

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] en;
        logic       m;
        logic [3:0] exp;
    } vec_t;

    vec_t vt [10];

    function automatic logic [31:0] wd(int ch, logic [26:0] p);
        return {2'b10, 3'(ch), p};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare one or both instances against the scoreboard head.
    task automatic sb_chk(string name, logic both);
        logic [31:0] e;
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, dat_b);
        end else begin
            e = sbq.pop_front();
            chk({name, "_stall"}, dat_b, e);
            if (both) chk({name, "_drop"}, dat_a, e);
        end
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic idle();
        CH_VALID   = '0;
        CH_ENABLE  = '1;
        MUTE       = 1'b0;
        CLEAR_LOST = 1'b0;
        FIFO_READ  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        BUS_RST = 1'b1;
        tick();
        tick();
        BUS_RST = 1'b0;
        sbq.delete();
    endtask

    task automatic set_data(int ch, logic [26:0] p);
        CH_DATA[27*ch +: 27] = p;
    endtask

    task automatic drain(int n, logic both);
        FIFO_READ = 1'b1;
        for (int i = 0; i < n; i++) begin
            sb_chk("drain", both);
            tick();
        end
        FIFO_READ = 1'b0;
    endtask

    initial begin
        // Combinational CH_READY vectors, pointer at reset value 3, FIFO empty.
        vt[0] = '{v:4'b0000, en:4'b1111, m:1'b0, exp:4'b0000};
        vt[1] = '{v:4'b0001, en:4'b1111, m:1'b0, exp:4'b0001};
        vt[2] = '{v:4'b1111, en:4'b1111, m:1'b0, exp:4'b0001};
        vt[3] = '{v:4'b1100, en:4'b1111, m:1'b0, exp:4'b0100};
        vt[4] = '{v:4'b1000, en:4'b1111, m:1'b0, exp:4'b1000};
        vt[5] = '{v:4'b1111, en:4'b1110, m:1'b0, exp:4'b0011};
        vt[6] = '{v:4'b1111, en:4'b0000, m:1'b0, exp:4'b1111};
        vt[7] = '{v:4'b1111, en:4'b1111, m:1'b1, exp:4'b1111};
        vt[8] = '{v:4'b0000, en:4'b1111, m:1'b1, exp:4'b1111};
        vt[9] = '{v:4'b1010, en:4'b0111, m:1'b0, exp:4'b1010};

        CH_DATA = '0;
        do_reset();

        // Reset state
        chk("rst_empty", {31'd0, emp_a & emp_b}, 32'd1);
        chk("rst_full", {31'd0, ful_a | ful_b}, 32'd0);
        chk("rst_data", dat_a | dat_b, 32'd0);
        chk("rst_lost", {24'd0, lost_a | lost_b}, 32'd0);
        chk("rst_err", {31'd0, err_a | err_b}, 32'd0);

        // Table: each vector applied and restored within one low phase.
        for (int i = 0; i < 10; i++) begin
            @(negedge BUS_CLK);
            CH_VALID  = vt[i].v;
            CH_ENABLE = vt[i].en;
            MUTE      = vt[i].m;
            #1;
            chk($sformatf("vec%0d_drop", i), {28'd0, rdy_a}, {28'd0, vt[i].exp});
            chk($sformatf("vec%0d_stall", i), {28'd0, rdy_b}, {28'd0, vt[i].exp});
            idle();
        end
        tick();
        chk("vec_noside", {31'd0, emp_a & emp_b}, 32'd1);

        // Single word latency and tag format
        do_reset();
        set_data(0, 27'h1234567);
        CH_VALID = 4'b0001;
        sbq.push_back(32'h81234567);
        tick();
        CH_VALID = '0;
        chk("lat_empty", {31'd0, emp_a}, 32'd0);
        sb_chk("lat_data", 1'b1);
        FIFO_READ = 1'b1;
        tick();
        FIFO_READ = 1'b0;
        chk("lat_pop", {31'd0, emp_a & emp_b}, 32'd1);

        // Round robin with all channels valid and reads held high
        do_reset();
        for (int c = 0; c < CH; c++) set_data(c, 27'(32'h100 + c));
        CH_VALID  = 4'b1111;
        FIFO_READ = 1'b1;
        sbq.push_back(wd(0, 27'h100));
        tick();
        for (int k = 1; k < 12; k++) begin
            sbq.push_back(wd(k % 4, 27'(32'h100 + (k % 4))));
            chk("rr_nonempty", {31'd0, emp_a}, 32'd0);
            sb_chk("rr_order", 1'b1);
            tick();
        end
        idle();

        // Drop on full, saturation, clear priority
        do_reset();
        CH_VALID = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            set_data(2, 27'(k));
            if (k < 16) sbq.push_back(wd(2, 27'(k)));
            tick();
            if (k == 14) chk("drop_notfull15", {31'd0, ful_a}, 32'd0);
            if (k == 15) chk("drop_full16", {31'd0, ful_a}, 32'd1);
        end
        chk("drop_lost4", {24'd0, lost_a}, 32'd4);
        chk("drop_err", {31'd0, err_a}, 32'd1);
        chk("stall_lost0", {24'd0, lost_b}, 32'd0);
        chk("drop_ready_full", {28'd0, rdy_a}, 32'h4);
        CH_VALID   = '0;
        CLEAR_LOST = 1'b1;
        tick();
        CLEAR_LOST = 1'b0;
        chk("clear_lost", {24'd0, lost_a}, 32'd0);
        chk("clear_err", {31'd0, err_a}, 32'd0);
        CH_VALID = 4'b0100;
        for (int k = 0; k < 300; k++) tick();
        chk("lost_sat", {24'd0, lost_a}, 32'd255);
        CLEAR_LOST = 1'b1;
        tick();
        CLEAR_LOST = 1'b0;
        CH_VALID   = '0;
        chk("clear_prio", {24'd0, lost_a}, 32'd0);
        drain(16, 1'b1);
        chk("drop_drained", {31'd0, emp_a & emp_b}, 32'd1);

        // Stall on full: word held, released by one read
        do_reset();
        CH_VALID = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            set_data(1, 27'(32'h200 + k));
            sbq.push_back(wd(1, 27'(32'h200 + k)));
            tick();
        end
        set_data(1, 27'h3AB);
        #1;
        chk("stall_rdy0", {31'd0, rdy_b[1]}, 32'd0);
        tick();
        tick();
        chk("stall_hold_full", {31'd0, ful_b}, 32'd1);
        chk("stall_hold_rdy", {31'd0, rdy_b[1]}, 32'd0);
        FIFO_READ = 1'b1;
        #1;
        chk("stall_samecyc", {31'd0, rdy_b[1]}, 32'd0);
        sb_chk("stall_head", 1'b0);
        tick();
        FIFO_READ = 1'b0;
        chk("stall_notfull", {31'd0, ful_b}, 32'd0);
        chk("stall_rdy1", {31'd0, rdy_b[1]}, 32'd1);
        sbq.push_back(wd(1, 27'h3AB));
        tick();
        CH_VALID = '0;
        chk("stall_refull", {31'd0, ful_b}, 32'd1);
        chk("stall_nolost", {24'd0, lost_b}, 32'd0);
        drain(16, 1'b0);
        chk("stall_drained", {31'd0, emp_b}, 32'd1);

        // Mute and disabled channel
        do_reset();
        MUTE     = 1'b1;
        CH_VALID = 4'b1111;
        for (int k = 0; k < 5; k++) tick();
        chk("mute_rdy", {28'd0, rdy_a}, 32'hF);
        chk("mute_empty", {31'd0, emp_a & emp_b}, 32'd1);
        chk("mute_lost", {24'd0, lost_a}, 32'd0);
        MUTE = 1'b0;
        #1;
        chk("mute_ptr_frozen", {28'd0, rdy_a}, 32'h1);
        CH_VALID  = 4'b1000;
        CH_ENABLE = 4'b0111;
        #1;
        for (int k = 0; k < 5; k++) tick();
        chk("dis_rdy", {28'd0, rdy_a}, 32'h8);
        chk("dis_empty", {31'd0, emp_a & emp_b}, 32'd1);
        chk("dis_lost", {24'd0, lost_a}, 32'd0);
        idle();

        // Empty reads, pointer wrap, simultaneous write/read
        do_reset();
        FIFO_READ = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        FIFO_READ = 1'b0;
        chk("under_empty", {31'd0, emp_a & emp_b}, 32'd1);
        chk("under_full", {31'd0, ful_a | ful_b}, 32'd0);
        chk("under_data", dat_a | dat_b, 32'd0);
        for (int k = 0; k < 20; k++) begin
            set_data(0, 27'(32'h400 + k));
            CH_VALID = 4'b0001;
            sbq.push_back(wd(0, 27'(32'h400 + k)));
            tick();
            CH_VALID = '0;
            sb_chk("wrap_data", 1'b1);
            FIFO_READ = 1'b1;
            tick();
            FIFO_READ = 1'b0;
            chk("wrap_empty", {31'd0, emp_a & emp_b}, 32'd1);
        end
        CH_VALID = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_data(0, 27'(32'h480 + k));
            sbq.push_back(wd(0, 27'(32'h480 + k)));
            tick();
        end
        FIFO_READ = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_data(0, 27'(32'h500 + k));
            sbq.push_back(wd(0, 27'(32'h500 + k)));
            #1;
            sb_chk("rw_data", 1'b1);
            tick();
            chk("rw_nonempty", {31'd0, emp_a}, 32'd0);
        end
        CH_VALID = '0;
        drain(3, 1'b1);
        chk("rw_end_empty", {31'd0, emp_a & emp_b}, 32'd1);

        // Reset during a transfer drops stored and incoming words
        CH_VALID = 4'b0001;
        tick();
        tick();
        BUS_RST = 1'b1;
        tick();
        BUS_RST  = 1'b0;
        CH_VALID = '0;
        tick();
        chk("midrst_empty", {31'd0, emp_a & emp_b}, 32'd1);
        chk("midrst_data", dat_a | dat_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
